cop0_regfile: RTL

- Architectural CP0 register file: holds BadVAddr, Count, Compare, Status, Cause, EPC, EBase and LLAddr.
- Consumes the masked mtc0 data produced by the cop0 write filter (`cop0_write_filter`) and merges it with hardware-owned fields.
- Hardware-owned updates come from exception entry, eret, the Count/Compare timer, external interrupt lines and ll.
- Supplies mfc0 read data and the pending-interrupt request to the pipeline.

---
 rtl/cop0_regfile.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cop0_regfile.sv
// Architectural CP0 register file: mtc0 merge, exception/eret sequencing,
// Count/Compare timer, interrupt sampling and mfc0 read port.
module cop0_regfile #(
    parameter int unsigned COUNT_DIV   = 2,
    parameter logic [31:0] EBASE_RESET = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  wrd,
    input  logic [2:0]  wsel,
    input  logic [31:0] wdata,
    input  logic [4:0]  rrd,
    input  logic [2:0]  rsel,
    output logic [31:0] rdata,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        exc_bva_valid,
    input  logic [31:0] exc_bva,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    input  logic        ll_valid,
    input  logic [31:0] ll_addr,
    output logic        int_req,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic [31:0] ebase_out
);

    localparam int unsigned DIV_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    localparam logic [31:0] STATUS_RESET = 32'h00400004;
    localparam logic [31:0] STATUS_MASK  = 32'h1040FF17;
    localparam logic [31:0] CAUSE_MASK   = 32'h00800300;
    localparam logic [31:0] EBASE_MASK   = 32'h3FFFF000;

    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;
    localparam int unsigned ST_ERL = 2;
    localparam int unsigned CA_BD  = 31;
    localparam int unsigned CA_TI  = 30;

    typedef enum logic [3:0] {
        R_NONE,
        R_BADVADDR,
        R_COUNT,
        R_COMPARE,
        R_STATUS,
        R_CAUSE,
        R_EPC,
        R_EBASE,
        R_LLADDR
    } reg_id_t;

    function automatic reg_id_t decode(input logic [4:0] rd, input logic [2:0] sel);
        reg_id_t id;
        case ({rd, sel})
            {5'd8,  3'd0}: id = R_BADVADDR;
            {5'd9,  3'd0}: id = R_COUNT;
            {5'd11, 3'd0}: id = R_COMPARE;
            {5'd12, 3'd0}: id = R_STATUS;
            {5'd13, 3'd0}: id = R_CAUSE;
            {5'd14, 3'd0}: id = R_EPC;
            {5'd15, 3'd1}: id = R_EBASE;
            {5'd17, 3'd0}: id = R_LLADDR;
            default:       id = R_NONE;
        endcase
        return id;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [31:0] mask);
        return (old & ~mask) | (nw & mask);
    endfunction

    logic [31:0] badvaddr, count, compare, status, cause, epc, ebase, lladdr;
    logic [31:0] badvaddr_n, count_n, compare_n, status_n, cause_n, epc_n, ebase_n, lladdr_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [31:0] ebase_merged;
    logic        wr_en;
    logic        ti_n;
    reg_id_t     wr_id;

    assign wr_id        = decode(wrd, wsel);
    assign wr_en        = we & ~exc_valid & ~eret;
    assign ebase_merged = merge(ebase, wdata, EBASE_MASK);

    always_comb begin
        badvaddr_n = badvaddr;
        count_n    = count;
        compare_n  = compare;
        status_n   = status;
        cause_n    = cause;
        epc_n      = epc;
        ebase_n    = ebase;
        lladdr_n   = lladdr;
        div_n      = div_cnt;
        ti_n       = cause[CA_TI];

        // Timer runs outside the exc/eret/mtc0 chain; only a surviving mtc0 touches it.
        if (wr_en && wr_id == R_COUNT) begin
            count_n = wdata;
            div_n   = '0;
        end else if (div_cnt == DIV_LAST) begin
            count_n = count + 32'd1;
            div_n   = '0;
        end else begin
            div_n = div_cnt + DIV_W'(1);
        end

        if (wr_en && wr_id == R_COMPARE) begin
            compare_n = wdata;
            ti_n      = 1'b0;
        end else if (count_n == compare) begin
            ti_n = 1'b1;
        end

        if (ll_valid) begin
            lladdr_n = ll_addr;
        end

        if (exc_valid) begin
            if (!status[ST_EXL]) begin
                epc_n          = exc_bd ? exc_pc - 32'd4 : exc_pc;
                cause_n[CA_BD] = exc_bd;
            end
            status_n[ST_EXL] = 1'b1;
            cause_n[6:2]     = exc_code;
            if (exc_bva_valid) begin
                badvaddr_n = exc_bva;
            end
        end else if (eret) begin
            if (status[ST_ERL]) begin
                status_n[ST_ERL] = 1'b0;
            end else begin
                status_n[ST_EXL] = 1'b0;
            end
        end else if (we) begin
            case (wr_id)
                R_STATUS: status_n = merge(status, wdata, STATUS_MASK);
                R_CAUSE:  cause_n  = merge(cause, wdata, CAUSE_MASK);
                R_EPC:    epc_n    = wdata;
                R_EBASE:  ebase_n  = {2'b10, ebase_merged[29:12], 12'h000};
                default:  ;
            endcase
        end

        cause_n[CA_TI]  = ti_n;
        cause_n[15]     = hw_int[5] | ti_n;
        cause_n[14:10]  = hw_int[4:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            badvaddr <= '0;
            count    <= '0;
            compare  <= '0;
            status   <= STATUS_RESET;
            cause    <= '0;
            epc      <= '0;
            ebase    <= EBASE_RESET;
            lladdr   <= '0;
            div_cnt  <= '0;
        end else begin
            badvaddr <= badvaddr_n;
            count    <= count_n;
            compare  <= compare_n;
            status   <= status_n;
            cause    <= cause_n;
            epc      <= epc_n;
            ebase    <= ebase_n;
            lladdr   <= lladdr_n;
            div_cnt  <= div_n;
        end
    end

    always_comb begin
        rdata = '0;
        case (decode(rrd, rsel))
            R_BADVADDR: rdata = badvaddr;
            R_COUNT:    rdata = count;
            R_COMPARE:  rdata = compare;
            R_STATUS:   rdata = status;
            R_CAUSE:    rdata = cause;
            R_EPC:      rdata = epc;
            R_EBASE:    rdata = ebase;
            R_LLADDR:   rdata = lladdr;
            default:    rdata = '0;
        endcase
    end

    assign int_req    = (|(cause[15:8] & status[15:8])) & status[ST_IE]
                        & ~status[ST_EXL] & ~status[ST_ERL];
    assign epc_out    = epc;
    assign status_out = status;
    assign ebase_out  = ebase;

endmodule
